// File: rtl/grid_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | grid_port_arbiter: round-robin arbiter sharing one grid/position RAM port;  |
// | optional lock feature under GRID_ARB_LOCK_EN.  Revision 1.0                 |
// +----------------------------------------------------------------------------+
module grid_port_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          we,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  input  logic [N_REQ-1:0]          lock,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      lock_err,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_din,
  input  logic [DATA_W-1:0]         mem_dout
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] k);
    return (k == PTR_W'(N_REQ - 1)) ? '0 : k + 1'b1;
  endfunction

  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [PTR_W-1:0]  arb_idx, search_idx, sel_idx;
  logic              arb_hit, sel_vld, grant;
  logic [N_REQ-1:0]  rvalid_r;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] din_hold;
  logic              lock_err_r;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    arb_hit    = 1'b0;
    arb_idx    = '0;
    search_idx = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!arb_hit && req[search_idx]) begin
        arb_hit = 1'b1;
        arb_idx = search_idx;
      end
      search_idx = wrap_inc(search_idx);
    end
  end

`ifdef GRID_ARB_LOCK_EN
  typedef enum logic [0:0] {ARB = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  owner, owner_nxt;
  logic [CNT_W-1:0]  idle_cnt, idle_cnt_nxt;
  logic              lock_err_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      owner      <= '0;
      idle_cnt   <= '0;
      lock_err_r <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      idle_cnt   <= idle_cnt_nxt;
      lock_err_r <= lock_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    idle_cnt_nxt = idle_cnt;
    lock_err_nxt = lock_err_r;
    ptr_nxt      = ptr;
    sel_idx      = arb_idx;
    sel_vld      = arb_hit;
    case (state)
      ARB: begin
        if (arb_hit) begin
          if (lock[arb_idx]) begin
            state_nxt    = LOCKED;
            owner_nxt    = arb_idx;
            idle_cnt_nxt = '0;
          end else begin
            ptr_nxt = wrap_inc(arb_idx);
          end
        end
      end
      LOCKED: begin
        sel_idx = owner;
        sel_vld = req[owner];
        if (req[owner]) begin
          if (lock[owner]) begin
            idle_cnt_nxt = '0;
          end else begin
            state_nxt = ARB;
            ptr_nxt   = wrap_inc(owner);
          end
        end else if (idle_cnt == CNT_W'(LOCK_MAX)) begin
          // Owner went quiet too long: forcibly release and flag it.
          state_nxt    = ARB;
          lock_err_nxt = 1'b1;
          ptr_nxt      = wrap_inc(owner);
        end else begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign lock_err_r  = 1'b0;

  always_comb begin
    sel_idx = arb_idx;
    sel_vld = arb_hit;
    ptr_nxt = arb_hit ? wrap_inc(arb_idx) : ptr;
  end
`endif

  assign gnt       = (sel_vld && !reset) ? ({{(N_REQ-1){1'b0}}, 1'b1} << sel_idx) : '0;
  assign grant     = |gnt;
  assign mem_read  = grant & ~we[sel_idx];
  assign mem_write = grant &  we[sel_idx];

  // Address/data hold their last granted values between grants.
  always_comb begin
    mem_addr = addr_hold;
    mem_din  = din_hold;
    if (reset) begin
      mem_addr = '0;
      mem_din  = '0;
    end else if (grant) begin
      mem_addr = addr[int'(sel_idx)*ADDR_W +: ADDR_W];
      mem_din  = wdata[int'(sel_idx)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      rvalid_r  <= '0;
      addr_hold <= '0;
      din_hold  <= '0;
    end else begin
      ptr      <= ptr_nxt;
      rvalid_r <= mem_read ? gnt : '0;
      if (grant) begin
        addr_hold <= mem_addr;
        din_hold  <= mem_din;
      end
    end
  end

  // RAM returns data the cycle after the read, alongside rvalid.
  assign rvalid   = reset ? '0 : rvalid_r;
  assign rdata    = (|rvalid) ? mem_dout : '0;
  assign lock_err = lock_err_r & ~reset;

endmodule
`default_nettype wire
